// File: rtl/cp0_exc_unit_pkg.sv
// ---------------------------------------------------------------------------
// cp0_exc_unit_pkg
//   Constants and helpers shared by CP0 and the per-stage exception
//   generators: ExcCode values, CP0 register numbers, SR/Cause bit
//   positions and the packed register images returned by mfc0.
// ---------------------------------------------------------------------------
package cp0_exc_unit_pkg;

    // ExcCode values carried down the D/E/M exception chain.
    // EXC_NONE marks "no exception pending" for the instruction.
    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12,
        EXC_NONE = 5'd31
    } exc_code_e;

    // CP0 register numbers (rd field of mfc0/mtc0)
    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    // SR bit positions
    localparam int SR_IE      = 0;
    localparam int SR_EXL     = 1;
    localparam int SR_IM_LO   = 10;
    localparam int SR_IM_HI   = 15;

    // Cause bit positions
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD     = 31;

    // Only the implemented fields are stored; everything else reads 0.
    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } sr_t;

    typedef struct packed {
        logic       bd;
        logic [5:0] ip;
        logic [4:0] exc;
    } cause_t;

    function automatic logic [31:0] sr_image(input sr_t s);
        logic [31:0] w;
        w                    = '0;
        w[SR_IM_HI:SR_IM_LO] = s.im;
        w[SR_EXL]            = s.exl;
        w[SR_IE]             = s.ie;
        return w;
    endfunction

    function automatic logic [31:0] cause_image(input cause_t c);
        logic [31:0] w;
        w                            = '0;
        w[CAUSE_BD]                  = c.bd;
        w[CAUSE_IP_HI:CAUSE_IP_LO]   = c.ip;
        w[CAUSE_EXC_HI:CAUSE_EXC_LO] = c.exc;
        return w;
    endfunction

endpackage

// File: rtl/cp0_int_sync.sv
// ---------------------------------------------------------------------------
// cp0_int_sync
//   STAGES-deep flop chain that brings the asynchronous hardware interrupt
//   lines into the core clock domain.
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous, active-low reset (chain clears to 0)
//   i_d    in   W asynchronous input lines
//   o_q    out  W synchronised lines (last stage of the chain)
// ---------------------------------------------------------------------------
module cp0_int_sync #(
    parameter int STAGES = 2,
    parameter int W      = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_chain [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_chain[i] <= '0;
            end
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/cp0_exc_unit.sv
// ---------------------------------------------------------------------------
// cp0_exc_unit
//   Coprocessor 0 for the pipelined MIPS core, located at the M stage.
//   Holds SR/Cause/EPC/PRId, synchronises external interrupts, decides
//   whether to trap this cycle, supplies the handler PC and the eret target,
//   and serves mfc0/mtc0.
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-low reset
//   pc_m        in   32  PC of the M-stage instruction
//   exccode_m   in   5   ExcCode of the M-stage instruction (EXC_NONE = none)
//   bd_m        in   1   M-stage instruction is in a branch delay slot
//   hwint       in   6   asynchronous external interrupt lines
//   cp0_we      in   1   mtc0 in M
//   cp0_addr    in   5   CP0 register number for mtc0/mfc0
//   cp0_din     in   32  mtc0 write data
//   eret_m      in   1   eret in M
//   cp0_dout    out  32  mfc0 read data (combinational, pre-edge values)
//   exc_take    out  1   trap this cycle (combinational)
//   handler_pc  out  32  trap vector
//   epc_out     out  32  eret target
// ---------------------------------------------------------------------------
module cp0_exc_unit
    import cp0_exc_unit_pkg::*;
#(
    parameter logic [31:0] PRID        = 32'h4D49_5053,
    parameter logic [31:0] HANDLER_PC  = 32'h0000_4180,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_m,
    input  logic [4:0]  exccode_m,
    input  logic        bd_m,
    input  logic [5:0]  hwint,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_din,
    input  logic        eret_m,
    output logic [31:0] cp0_dout,
    output logic        exc_take,
    output logic [31:0] handler_pc,
    output logic [31:0] epc_out
);

    sr_t         r_sr;
    cause_t      r_cause;
    logic [31:0] r_epc;

    logic [5:0]  w_hw_s;
    logic        w_int_req;
    logic        w_exc_req;
    logic        w_take;
    logic        w_wr_sr;
    logic        w_wr_epc;

    cp0_int_sync #(
        .STAGES (SYNC_STAGES),
        .W      (6)
    ) u_int_sync (
        .clk   (clk),
        .rst_n (reset),
        .i_d   (hwint),
        .o_q   (w_hw_s)
    );

    // Trap decision uses registered SR only, so it is stable for the whole
    // cycle. EXL masks both sources: nested traps are not supported.
    assign w_int_req = (|(w_hw_s & r_sr.im)) & r_sr.ie & ~r_sr.exl;
    assign w_exc_req = (exccode_m != EXC_NONE) & ~r_sr.exl;
    assign w_take    = w_int_req | w_exc_req;

    // Gated by reset so a trap request disappears the moment reset asserts,
    // even while an exception code is still presented by the pipeline.
    assign exc_take   = reset & w_take;
    assign handler_pc = HANDLER_PC;

    assign w_wr_sr  = cp0_we & (cp0_addr == CP0_SR);
    assign w_wr_epc = cp0_we & (cp0_addr == CP0_EPC);

    // eret reading an EPC that the same M-stage mtc0 is writing sees the
    // new value, not the stale register.
    assign epc_out = (eret_m & w_wr_epc) ? cp0_din : r_epc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sr    <= '0;
            r_cause <= '0;
            r_epc   <= '0;
        end else begin
            // IP mirrors the synchronised lines every cycle, trap or not.
            r_cause.ip <= w_hw_s;
            if (w_take) begin
                // Trapping instruction is flushed: coincident eret/mtc0 dropped.
                r_sr.exl    <= 1'b1;
                r_cause.exc <= w_int_req ? EXC_INT : exccode_m;
                r_cause.bd  <= bd_m;
                r_epc       <= bd_m ? (pc_m - 32'd4) : pc_m;
            end else begin
                if (w_wr_sr) begin
                    r_sr.im  <= cp0_din[SR_IM_HI:SR_IM_LO];
                    r_sr.exl <= cp0_din[SR_EXL];
                    r_sr.ie  <= cp0_din[SR_IE];
                end
                // eret outranks mtc0 on EXL: this later assignment wins.
                if (eret_m) begin
                    r_sr.exl <= 1'b0;
                end
                if (w_wr_epc) begin
                    r_epc <= cp0_din;
                end
            end
        end
    end

    always_comb begin
        cp0_dout = '0;
        case (cp0_addr)
            CP0_SR:    cp0_dout = sr_image(r_sr);
            CP0_CAUSE: cp0_dout = cause_image(r_cause);
            CP0_EPC:   cp0_dout = r_epc;
            CP0_PRID:  cp0_dout = PRID;
            default:   cp0_dout = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
module tb_cp0_exc_unit;

  localparam logic [31:0] PRID_V = 32'h4D49_5053;
  localparam logic [31:0] HPC_V  = 32'h0000_4180;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_m;
  logic [4:0]  exccode_m;
  logic        bd_m;
  logic [5:0]  hwint;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_din;
  logic        eret_m;
  logic [31:0] cp0_dout;
  logic        exc_take;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;

  always #5 clk = ~clk;

  cp0_exc_unit dut (
    .clk        (clk),
    .reset      (reset),
    .pc_m       (pc_m),
    .exccode_m  (exccode_m),
    .bd_m       (bd_m),
    .hwint      (hwint),
    .cp0_we     (cp0_we),
    .cp0_addr   (cp0_addr),
    .cp0_din    (cp0_din),
    .eret_m     (eret_m),
    .cp0_dout   (cp0_dout),
    .exc_take   (exc_take),
    .handler_pc (handler_pc),
    .epc_out    (epc_out)
  );

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got %h but expected queue is empty", tag, obs);
    end else begin
      check_val(tag, obs, exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    cp0_we    = 1'b0;
    eret_m    = 1'b0;
    exccode_m = 5'h1f;
    bd_m      = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [4:0] a, input string tag);
    cp0_addr = a;
    #1;
    pop_chk(tag, cp0_dout);
  endtask

  task automatic take_chk(input string tag);
    #1;
    pop_chk(tag, {31'b0, exc_take});
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_we   = 1'b1;
    cp0_addr = a;
    cp0_din  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] v;
    reset = 1'b0; hwint = '0; pc_m = '0; cp0_addr = '0; cp0_din = '0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    push_exp(32'h0); take_chk("rst_take");
    push_exp(32'h0); read_reg(5'd12, "rst_sr");
    push_exp(32'h0); read_reg(5'd13, "rst_cause");
    push_exp(32'h0); read_reg(5'd14, "rst_epc");
    push_exp(32'h0); #1; pop_chk("rst_epc_out", epc_out);
    reset = 1'b1;
    tick();

    // 1: idle after reset
    push_exp(32'h0);  read_reg(5'd12, "t1_sr");
    push_exp(32'h0);  read_reg(5'd13, "t1_cause");
    push_exp(32'h0);  read_reg(5'd14, "t1_epc");
    push_exp(PRID_V); read_reg(5'd15, "t1_prid");
    push_exp(32'h0);  read_reg(5'd3,  "t1_other");
    push_exp(HPC_V);  #1; pop_chk("t1_handler", handler_pc);
    push_exp(32'h0);  take_chk("t1_take");
    tick();

    // 2: Ov, not in delay slot
    pc_m = 32'h3010; exccode_m = 5'd12; bd_m = 1'b0;
    push_exp(32'h1); take_chk("t2_take");
    tick(); idle();
    push_exp(32'h3010); read_reg(5'd14, "t2_epc");
    push_exp(32'h30);   read_reg(5'd13, "t2_cause");
    push_exp(32'h2);    read_reg(5'd12, "t2_sr");

    // eret alone returns EPC and clears EXL
    eret_m = 1'b1;
    push_exp(32'h3010); #1; pop_chk("t2_eret_epc_out", epc_out);
    tick(); idle();
    push_exp(32'h0); read_reg(5'd12, "t2_sr_after_eret");

    // 3: AdES in delay slot, then masked exception while EXL=1
    pc_m = 32'h3024; exccode_m = 5'd5; bd_m = 1'b1;
    push_exp(32'h1); take_chk("t3_take");
    tick(); idle();
    push_exp(32'h3020);      read_reg(5'd14, "t3_epc");
    push_exp(32'h8000_0014); read_reg(5'd13, "t3_cause");
    push_exp(32'h2);         read_reg(5'd12, "t3_sr");
    pc_m = 32'h3030; exccode_m = 5'd4;
    push_exp(32'h0); take_chk("t3_nested_take");
    tick(); idle();
    push_exp(32'h8000_0014); read_reg(5'd13, "t3_cause_kept");
    push_exp(32'h3020);      read_reg(5'd14, "t3_epc_kept");
    push_exp(32'h2);         read_reg(5'd12, "t3_sr_kept");

    // 4: interrupt through the synchroniser
    eret_m = 1'b1;
    tick(); idle();
    mtc0(5'd12, 32'h0000_0401);
    tick(); idle();
    push_exp(32'h401); read_reg(5'd12, "t4_sr");
    pc_m = 32'h3050; hwint = 6'h01;
    push_exp(32'h0); take_chk("t4_take_c0");
    tick();
    push_exp(32'h0); take_chk("t4_take_c1");
    tick();
    push_exp(32'h1); take_chk("t4_take_c2");
    tick();
    push_exp(32'h400);  read_reg(5'd13, "t4_cause");
    push_exp(32'h403);  read_reg(5'd12, "t4_sr_exl");
    push_exp(32'h3050); read_reg(5'd14, "t4_epc");
    push_exp(32'h0);    take_chk("t4_take_masked");
    // drain the line, return, then interrupt and Ov in the same cycle
    hwint = 6'h00;
    tick(); tick();
    eret_m = 1'b1;
    tick(); idle();
    hwint = 6'h01;
    tick(); tick();
    pc_m = 32'h3058; exccode_m = 5'd12;
    push_exp(32'h1); take_chk("t4_prio_take");
    tick(); idle();
    push_exp(32'h400); read_reg(5'd13, "t4_prio_cause");

    // 5: eret with EPC bypass, then eret alone
    hwint = 6'h00;
    tick(); tick();
    mtc0(5'd14, 32'h3040);
    tick(); idle();
    push_exp(32'h3040); read_reg(5'd14, "t5_epc");
    eret_m = 1'b1; mtc0(5'd14, 32'h3100);
    push_exp(32'h3100); #1; pop_chk("t5_bypass", epc_out);
    tick(); idle();
    push_exp(32'h401);  read_reg(5'd12, "t5_sr");
    push_exp(32'h3100); read_reg(5'd14, "t5_epc_new");
    mtc0(5'd14, 32'h3040);
    tick(); idle();
    eret_m = 1'b1;
    push_exp(32'h3040); #1; pop_chk("t5_eret_alone", epc_out);
    tick(); idle();

    // 6: trap discards coincident mtc0/eret; async reset mid-trap
    pc_m = 32'h3060; exccode_m = 5'd10; eret_m = 1'b1; mtc0(5'd12, 32'h0);
    push_exp(32'h1); take_chk("t6_take");
    tick(); idle();
    push_exp(32'h403);  read_reg(5'd12, "t6_sr");
    push_exp(32'h3060); read_reg(5'd14, "t6_epc");
    push_exp(32'h28);   read_reg(5'd13, "t6_cause");
    exccode_m = 5'd12;
    reset = 1'b0;
    push_exp(32'h0); read_reg(5'd12, "t6_rst_sr");
    push_exp(32'h0); read_reg(5'd13, "t6_rst_cause");
    push_exp(32'h0); read_reg(5'd14, "t6_rst_epc");
    push_exp(32'h0); take_chk("t6_rst_take");
    idle();
    reset = 1'b1;
    tick();

    // random mtc0/mfc0 round trips
    for (int i = 0; i < 8; i++) begin
      v = $urandom;
      push_exp(v);
      mtc0(5'd14, v);
      tick(); idle();
      read_reg(5'd14, "rnd_epc");
      v = $urandom;
      push_exp(v & 32'h0000_FC03);
      mtc0(5'd12, v);
      tick(); idle();
      read_reg(5'd12, "rnd_sr");
      v = $urandom_range(16, 31);
      push_exp(32'h0);
      cp0_addr = v[4:0];
      #1;
      pop_chk("rnd_unimpl", (v[4:0] == 5'd15) ? (cp0_dout ^ PRID_V) : cp0_dout);
      tick();
    end

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d expected values never compared", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
